time_set_m: RTL and testbench
=============================

# time_set_m

Time/alarm setting controller for the seconds-timestamp clock. In RUN it passes through and toggles alarm enable. In set mode it captures the current timestamp, splits it into hour/minute fields with an iterative decoder, and lets the user edit clock and alarm fields with mode/up/down pulses. It commits results to the master counter and alarm modules through one-cycle load strobes. It sits between the user-input path and the counter/alarm modules; the coordination module routes its strobes.

## Interface
- DAY_SECONDS, 86400: timestamp modulus; valid timestamps are 0..86399.
- TIMEOUT_CYCLES, 30: idle clock cycles in any SET state before the edit is abandoned.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces the reset state immediately.
- counter_state  in  17  current timestamp from the counter module.
- btn_mode, btn_up, btn_down, btn_alarm_en  in  1 each  single-cycle pulses, debounced upstream.
- set_load  out  1  one-cycle strobe; counter loads set_value.
- set_value  out  17  hr*3600 + min*60 (seconds field = 0).
- alarm_load  out  1  one-cycle strobe; alarm module loads alarm_value.
- alarm_value  out  17  alarm setpoint, ahr*3600 + amin*60.
- alarm_enable  out  1  alarm armed flag.
- edit_mode  out  3  state code for display: RUN=0, DEC=1, SET_HR=2, SET_MIN=3, SET_AHR=4, SET_AMIN=5.
- edit_hr  out  5, edit_min  out  6  field currently shown/edited.

## Operation
- Reset values:
  - State RUN; all strobes 0; set_value 0; alarm_value 0; alarm_enable 0.
  - edit_hr/edit_min 0; alarm fields ahr/amin 0; timeout counter 0.
- RUN:
  - btn_alarm_en toggles alarm_enable.
  - btn_mode latches counter_state into the decoder and goes to DEC.
  - btn_up/btn_down are ignored.
- DEC:
  - The decoder subtracts 3600 per cycle while remainder >= 3600, incrementing hr.
  - It then subtracts 60 per cycle while remainder >= 60, incrementing min.
  - The seconds remainder is discarded. On done, load edit_hr/edit_min and go to SET_HR.
  - All buttons are ignored in DEC.
- SET_HR / SET_AHR, edit hr (or ahr), 0..23:
  - up: 23 wraps to 0, otherwise +1.
  - down: 0 wraps to 23, otherwise -1.
- SET_MIN / SET_AMIN, edit min (or amin), 0..59, same wrap rules at 59/0.
- Minute edits never carry into the hour field.
- Transitions on btn_mode:
  - SET_HR -> SET_MIN.
  - SET_MIN -> SET_AHR: set_load pulses with the composed value; edit fields switch to ahr/amin.
  - SET_AHR -> SET_AMIN.
  - SET_AMIN -> RUN: alarm_load pulses with the composed alarm value.
- Timeout:
  - The counter clears on any button pulse and on state entry; it increments each cycle in SET states.
  - At TIMEOUT_CYCLES it returns to RUN with no strobe, and pending field edits are discarded.
  - An already-committed clock time stays committed.
  - Alarm fields ahr/amin revert to the last loaded alarm_value.
- Simultaneous pulses: btn_mode has priority over up/down; up and down together means no change. btn_alarm_en is ignored outside RUN.
- Arithmetic: compose with constant multiplies into 17 bits; the result is always < DAY_SECONDS, so no saturation logic is needed.

## Timing
- All outputs are registered.
- Edit field updates are visible the cycle after the button pulse.
- set_load/alarm_load are high exactly one cycle, the cycle after the committing btn_mode pulse; set_value/alarm_value are valid in that same cycle and hold afterwards.
- DEC latency = 1 capture cycle + hr + min + 1 cycles; worst case 23:59:xx = 84 cycles.
- A counter_state change during DEC is not tracked; the captured value is used.
- Reset asserted mid-DEC or mid-SET aborts with no strobe; all state returns to reset values.

## Structure
- Shared package:
  - COUNTER_T (unsigned [16:0]), ALARM_T.
  - DAY_SECONDS, SEC_PER_HR = 3600, SEC_PER_MIN = 60.
  - edit_mode state codes.
- Sub-module sec_decode_m: iterative timestamp-to-hr/min decoder with start/done handshake.
  - start: 1-cycle pulse with the value.
  - done: 1-cycle pulse with hr/min valid.
  - busy between start and done.
- time_set_m holds the FSM, field registers, timeout counter and compose logic.

## Test plan
- Reset, then btn_alarm_en pulse in RUN:
  - Under reset: all outputs 0, edit_mode 0.
  - After the pulse: alarm_enable 1; a second pulse returns it to 0.
- counter_state 45296 (12:34:56), btn_mode: DEC completes in 48 cycles, edit_mode 2, edit_hr 12, edit_min 34.
- From that state:
  - 12 up pulses: edit_hr 0.
  - mode, then 1 down: edit_min 33.
  - mode: set_load one cycle with set_value 1980; edit_mode 4.
- In SET_AMIN from amin 0, one down pulse:
  - Result: amin 59.
  - Then up+down in the same cycle: no change.
  - Then mode: alarm_load with value ahr*3600 + 3540; edit_mode 0.
- Enter SET_AHR, press up twice, then idle TIMEOUT_CYCLES cycles:
  - Returns to RUN with no alarm_load; alarm_value unchanged; ahr reverted.
- Reset asserted mid-DEC (counter_state 86399): immediate RUN, no strobes; after release, btn_mode decodes to 23:59 in 84 cycles.

Source files
------------

// File: rtl/time_set_m_pkg.sv
// -----------------------------------------------------------------------------
// time_set_m_pkg
// Shared types, constants and helpers for the time/alarm setting controller.
//   counter_t / alarm_t : 17-bit seconds-of-day timestamp (0..86399)
//   edit_mode_e         : controller state, doubles as the display mode code
//   wrap_step()         : +1/-1 with wrap at 0 and a field maximum
//   compose()           : hr/min -> seconds-of-day with the seconds field at 0
// -----------------------------------------------------------------------------
package time_set_m_pkg;

    localparam int DAY_SECONDS    = 86400;
    localparam int SEC_PER_HR     = 3600;
    localparam int SEC_PER_MIN    = 60;
    localparam int TIMEOUT_CYCLES = 30;

    localparam logic [5:0] HR_MAX  = 6'd23;
    localparam logic [5:0] MIN_MAX = 6'd59;

    typedef logic [16:0] counter_t;
    typedef counter_t    alarm_t;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_DEC      = 3'd1,
        ST_SET_HR   = 3'd2,
        ST_SET_MIN  = 3'd3,
        ST_SET_AHR  = 3'd4,
        ST_SET_AMIN = 3'd5
    } edit_mode_e;

    // Step a field one count up or down, wrapping between 0 and max_v.
    function automatic logic [5:0] wrap_step(input logic [5:0] v,
                                             input logic [5:0] max_v,
                                             input logic       up);
        logic [5:0] r;
        if (up) r = (v == max_v) ? 6'd0 : v + 6'd1;
        else    r = (v == 6'd0)  ? max_v : v - 6'd1;
        return r;
    endfunction

    // hr*3600 + min*60; never reaches DAY_SECONDS for in-range fields.
    function automatic counter_t compose(input logic [4:0] hr,
                                         input logic [5:0] mn);
        return counter_t'(hr) * counter_t'(SEC_PER_HR)
             + counter_t'(mn) * counter_t'(SEC_PER_MIN);
    endfunction

endpackage

// File: rtl/time_set_m_sec_decode.sv
// -----------------------------------------------------------------------------
// sec_decode_m
// Iterative seconds-of-day to hour/minute decoder. One subtraction per cycle:
// 3600s while the remainder allows, then 60s; leftover seconds are dropped.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   i_start      : one-cycle pulse, i_value captured on that edge
//   i_value      : timestamp to decode
//   o_busy       : high from the capture edge until the done cycle ends
//   o_done       : one-cycle pulse, o_hr/o_min valid in that cycle
//   o_hr, o_min  : decoded fields
// -----------------------------------------------------------------------------
module sec_decode_m
    import time_set_m_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       i_start,
    input  counter_t   i_value,
    output logic       o_busy,
    output logic       o_done,
    output logic [4:0] o_hr,
    output logic [5:0] o_min
);

    logic       r_busy;
    counter_t   r_rem;
    logic [4:0] r_hr;
    logic [5:0] r_min;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_rem  <= '0;
            r_hr   <= '0;
            r_min  <= '0;
        end else if (i_start && !r_busy) begin
            r_busy <= 1'b1;
            r_rem  <= i_value;
            r_hr   <= '0;
            r_min  <= '0;
        end else if (r_busy) begin
            if (r_rem >= counter_t'(SEC_PER_HR)) begin
                r_rem <= r_rem - counter_t'(SEC_PER_HR);
                r_hr  <= r_hr + 5'd1;
            end else if (r_rem >= counter_t'(SEC_PER_MIN)) begin
                r_rem <= r_rem - counter_t'(SEC_PER_MIN);
                r_min <= r_min + 6'd1;
            end else begin
                r_busy <= 1'b0;
            end
        end
    end

    // Done as soon as the remainder is below one minute, so the consumer
    // can take the fields on the very next edge with no extra flag cycle.
    assign o_busy = r_busy;
    assign o_done = r_busy && (r_rem < counter_t'(SEC_PER_MIN));
    assign o_hr   = r_hr;
    assign o_min  = r_min;

endmodule

// File: rtl/time_set_m.sv
// -----------------------------------------------------------------------------
// time_set_m
// Time/alarm setting controller. RUN passes through and toggles alarm enable;
// btn_mode captures the current timestamp, decodes it, then walks through
// clock hour/minute and alarm hour/minute edit states, committing through
// one-cycle load strobes. Idle SET states time out back to RUN.
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   counter_state       : current timestamp from the counter module
//   btn_mode/up/down    : single-cycle debounced pulses
//   btn_alarm_en        : toggles alarm_enable (RUN only)
//   set_load/set_value  : clock commit strobe and value
//   alarm_load/_value   : alarm commit strobe and value
//   alarm_enable        : alarm armed flag
//   edit_mode           : state code for the display
//   edit_hr/edit_min    : field pair currently shown/edited
// -----------------------------------------------------------------------------
module time_set_m
    import time_set_m_pkg::*;
#(
    parameter int TIMEOUT_CYCLES_P = TIMEOUT_CYCLES
) (
    input  logic       clock,
    input  logic       reset,
    input  counter_t   counter_state,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_alarm_en,
    output logic       set_load,
    output counter_t   set_value,
    output logic       alarm_load,
    output alarm_t     alarm_value,
    output logic       alarm_enable,
    output logic [2:0] edit_mode,
    output logic [4:0] edit_hr,
    output logic [5:0] edit_min
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES_P + 1);

    edit_mode_e      r_state;
    edit_mode_e      w_next;
    logic [TO_W-1:0] r_timeout;
    logic [4:0]      r_edit_hr;
    logic [5:0]      r_edit_min;
    logic [4:0]      r_ahr;
    logic [5:0]      r_amin;
    logic            r_set_load;
    counter_t        r_set_value;
    logic            r_alarm_load;
    alarm_t          r_alarm_value;
    logic            r_alarm_enable;

    logic            w_dec_start;
    logic            w_dec_busy;
    logic            w_dec_done;
    logic [4:0]      w_dec_hr;
    logic [5:0]      w_dec_min;
    logic            w_any_btn;
    logic            w_up;
    logic            w_down;
    logic            w_is_set;
    logic            w_timeout;

    sec_decode_m u_dec (
        .clock   (clock),
        .reset   (reset),
        .i_start (w_dec_start),
        .i_value (counter_state),
        .o_busy  (w_dec_busy),
        .o_done  (w_dec_done),
        .o_hr    (w_dec_hr),
        .o_min   (w_dec_min)
    );

    // Up and down together cancel; mode outranks both where it is decoded.
    assign w_any_btn   = btn_mode | btn_up | btn_down | btn_alarm_en;
    assign w_up        = btn_up & ~btn_down;
    assign w_down      = btn_down & ~btn_up;
    assign w_is_set    = (r_state != ST_RUN) && (r_state != ST_DEC);
    assign w_timeout   = w_is_set && !w_any_btn
                      && (r_timeout == TO_W'(TIMEOUT_CYCLES_P - 1));
    assign w_dec_start = (r_state == ST_RUN) && btn_mode && !w_dec_busy;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_RUN;
        else       r_state <= w_next;
    end

    // NOTE: default assigned first so no path through the case infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RUN:      if (btn_mode)   w_next = ST_DEC;
            ST_DEC:      if (w_dec_done) w_next = ST_SET_HR;
            ST_SET_HR:   if (btn_mode)   w_next = ST_SET_MIN;
            ST_SET_MIN:  if (btn_mode)   w_next = ST_SET_AHR;
            ST_SET_AHR:  if (btn_mode)   w_next = ST_SET_AMIN;
            ST_SET_AMIN: if (btn_mode)   w_next = ST_RUN;
            default:                     w_next = ST_RUN;
        endcase
        if (w_timeout) w_next = ST_RUN;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_timeout      <= '0;
            r_edit_hr      <= '0;
            r_edit_min     <= '0;
            r_ahr          <= '0;
            r_amin         <= '0;
            r_set_load     <= 1'b0;
            r_set_value    <= '0;
            r_alarm_load   <= 1'b0;
            r_alarm_value  <= '0;
            r_alarm_enable <= 1'b0;
        end else begin
            r_set_load   <= 1'b0;
            r_alarm_load <= 1'b0;

            if (w_next != r_state || w_any_btn) r_timeout <= '0;
            else if (w_is_set)                  r_timeout <= r_timeout + TO_W'(1);

            case (r_state)
                ST_RUN: begin
                    if (btn_alarm_en) r_alarm_enable <= ~r_alarm_enable;
                end
                ST_DEC: begin
                    if (w_dec_done) begin
                        r_edit_hr  <= w_dec_hr;
                        r_edit_min <= w_dec_min;
                    end
                end
                ST_SET_HR, ST_SET_AHR: begin
                    if (w_timeout && r_state == ST_SET_AHR) begin
                        // Abandoned alarm edit: show the last loaded alarm again.
                        r_edit_hr  <= r_ahr;
                        r_edit_min <= r_amin;
                    end else if (!btn_mode && (w_up || w_down)) begin
                        r_edit_hr <= 5'(wrap_step({1'b0, r_edit_hr}, HR_MAX, w_up));
                    end
                end
                ST_SET_MIN: begin
                    if (btn_mode) begin
                        r_set_load  <= 1'b1;
                        r_set_value <= compose(r_edit_hr, r_edit_min);
                        r_edit_hr   <= r_ahr;
                        r_edit_min  <= r_amin;
                    end else if (w_up || w_down) begin
                        r_edit_min <= wrap_step(r_edit_min, MIN_MAX, w_up);
                    end
                end
                ST_SET_AMIN: begin
                    if (w_timeout) begin
                        r_edit_hr  <= r_ahr;
                        r_edit_min <= r_amin;
                    end else if (btn_mode) begin
                        r_alarm_load  <= 1'b1;
                        r_alarm_value <= compose(r_edit_hr, r_edit_min);
                        r_ahr         <= r_edit_hr;
                        r_amin        <= r_edit_min;
                    end else if (w_up || w_down) begin
                        r_edit_min <= wrap_step(r_edit_min, MIN_MAX, w_up);
                    end
                end
                default: ;
            endcase
        end
    end

    assign set_load     = r_set_load;
    assign set_value    = r_set_value;
    assign alarm_load   = r_alarm_load;
    assign alarm_value  = r_alarm_value;
    assign alarm_enable = r_alarm_enable;
    assign edit_mode    = r_state;
    assign edit_hr      = r_edit_hr;
    assign edit_min     = r_edit_min;

endmodule

// File: tb/tb_time_set_m.sv
// -----------------------------------------------------------------------------
// tb_time_set_m
// Directed self-checking bench for time_set_m. Inputs change on the falling
// edge; outputs are sampled 1ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_time_set_m;

    logic        clock = 1'b0;
    logic        reset;
    logic [16:0] counter_state;
    logic        btn_mode, btn_up, btn_down, btn_alarm_en;
    logic        set_load, alarm_load, alarm_enable;
    logic [16:0] set_value, alarm_value;
    logic [2:0]  edit_mode;
    logic [4:0]  edit_hr;
    logic [5:0]  edit_min;

    int n_cmp = 0;
    int n_err = 0;
    int n_cyc;
    int seen_aload;

    time_set_m dut (
        .clock         (clock),
        .reset         (reset),
        .counter_state (counter_state),
        .btn_mode      (btn_mode),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_alarm_en  (btn_alarm_en),
        .set_load      (set_load),
        .set_value     (set_value),
        .alarm_load    (alarm_load),
        .alarm_value   (alarm_value),
        .alarm_enable  (alarm_enable),
        .edit_mode     (edit_mode),
        .edit_hr       (edit_hr),
        .edit_min      (edit_min)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One-cycle button pulse; returns 1ns after the sampling edge.
    task automatic press(input logic m, input logic u, input logic d, input logic a);
        @(negedge clock);
        btn_mode = m; btn_up = u; btn_down = d; btn_alarm_en = a;
        @(posedge clock);
        #1;
        btn_mode = 0; btn_up = 0; btn_down = 0; btn_alarm_en = 0;
    endtask

    // btn_mode in RUN, then count edges (capture edge included) until SET_HR.
    task automatic decode(output int n);
        n = 0;
        @(negedge clock);
        btn_mode = 1;
        @(posedge clock);
        #1;
        btn_mode = 0;
        n = 1;
        check("dec_state", edit_mode, 1);
        while (edit_mode != 3'd2 && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1; counter_state = '0;
        btn_mode = 0; btn_up = 0; btn_down = 0; btn_alarm_en = 0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_set_load",  set_load, 0);
        check("rst_alarm_load", alarm_load, 0);
        check("rst_set_value", set_value, 0);
        check("rst_alarm_val", alarm_value, 0);
        check("rst_alarm_en",  alarm_enable, 0);
        check("rst_mode",      edit_mode, 0);
        check("rst_hr",        edit_hr, 0);
        check("rst_min",       edit_min, 0);
        @(negedge clock);
        reset = 0;

        // Alarm enable toggle in RUN
        press(0, 0, 0, 1);
        check("aen_on", alarm_enable, 1);
        press(0, 0, 0, 1);
        check("aen_off", alarm_enable, 0);

        // Decode 12:34:56: 1 + 12 + 34 + 1 = 48 edges
        counter_state = 17'd45296;
        decode(n_cyc);
        check("dec1_cycles", n_cyc, 48);
        check("dec1_mode", edit_mode, 2);
        check("dec1_hr", edit_hr, 12);
        check("dec1_min", edit_min, 34);

        // Hour wrap 23 -> 0 on the 12th up pulse
        for (int i = 0; i < 11; i++) press(0, 1, 0, 0);
        check("hr_23", edit_hr, 23);
        press(0, 1, 0, 0);
        check("hr_wrap0", edit_hr, 0);
        check("hr_min_kept", edit_min, 34);

        press(1, 0, 0, 0);
        check("to_set_min", edit_mode, 3);
        press(0, 0, 1, 0);
        check("min_33", edit_min, 33);
        check("min_no_carry", edit_hr, 0);

        // Clock commit: 0*3600 + 33*60 = 1980
        press(1, 0, 0, 0);
        check("set_load_hi", set_load, 1);
        check("set_value", set_value, 1980);
        check("to_set_ahr", edit_mode, 4);
        check("ahr_shown", edit_hr, 0);
        check("amin_shown", edit_min, 0);
        @(posedge clock);
        #1;
        check("set_load_lo", set_load, 0);
        check("set_value_hold", set_value, 1980);

        // Alarm hour: 0 down -> 23, up -> 0, up twice -> 2
        press(0, 0, 1, 0);
        check("ahr_wrap23", edit_hr, 23);
        press(0, 1, 0, 0);
        check("ahr_wrap0", edit_hr, 0);
        press(0, 1, 0, 0);
        press(0, 1, 0, 0);
        check("ahr_2", edit_hr, 2);
        press(1, 0, 0, 0);
        check("to_set_amin", edit_mode, 5);

        // Alarm minute: 0 down -> 59, up+down no change
        press(0, 0, 1, 0);
        check("amin_59", edit_min, 59);
        press(0, 1, 1, 0);
        check("amin_updown", edit_min, 59);
        press(0, 0, 0, 1);
        check("aen_ignored_set", alarm_enable, 0);

        // Alarm commit: 2*3600 + 59*60 = 10740
        press(1, 0, 0, 0);
        check("alarm_load_hi", alarm_load, 1);
        check("alarm_value", alarm_value, 10740);
        check("back_run", edit_mode, 0);
        @(posedge clock);
        #1;
        check("alarm_load_lo", alarm_load, 0);

        // Up/down ignored in RUN
        press(0, 1, 0, 0);
        check("run_up_mode", edit_mode, 0);
        check("run_up_hr", edit_hr, 2);

        // Decode 01:01:01: 1 + 1 + 1 + 1 = 4 edges, then commit 3660
        counter_state = 17'd3661;
        decode(n_cyc);
        check("dec2_cycles", n_cyc, 4);
        check("dec2_hr", edit_hr, 1);
        check("dec2_min", edit_min, 1);
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        check("set2_value", set_value, 3660);
        check("ahr_stored", edit_hr, 2);
        check("amin_stored", edit_min, 59);

        // Timeout in SET_AHR after two up pulses
        press(0, 1, 0, 0);
        press(0, 1, 0, 0);
        check("ahr_4", edit_hr, 4);
        seen_aload = 0;
        for (int i = 0; i < 29; i++) begin
            @(posedge clock);
            #1;
            if (alarm_load) seen_aload++;
        end
        check("to_not_yet", edit_mode, 4);
        @(posedge clock);
        #1;
        if (alarm_load) seen_aload++;
        check("to_run", edit_mode, 0);
        check("to_no_aload", seen_aload, 0);
        check("to_alarm_val", alarm_value, 10740);
        check("to_ahr_revert", edit_hr, 2);
        check("to_set_kept", set_value, 3660);

        // Reset mid-DEC of 23:59:59
        counter_state = 17'd86399;
        press(1, 0, 0, 0);
        repeat (10) @(posedge clock);
        #1;
        check("mid_dec", edit_mode, 1);
        #2;
        reset = 1;
        #1;
        check("rst2_mode", edit_mode, 0);
        check("rst2_set_load", set_load, 0);
        check("rst2_alarm_load", alarm_load, 0);
        check("rst2_set_value", set_value, 0);
        check("rst2_alarm_val", alarm_value, 0);
        @(negedge clock);
        reset = 0;
        decode(n_cyc);
        check("dec3_cycles", n_cyc, 84);
        check("dec3_hr", edit_hr, 23);
        check("dec3_min", edit_min, 59);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
